// File: rtl/vga_timing_gen.sv
// VGA timing generator. Produces a pixel-request interface with zero added latency and
// DAC/sync outputs re-aligned to a pixel source of PIPE_LAT clocks, plus optional colour bars.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIPE_LAT = 2,
    parameter int   COLOR_W  = 8
) (
    input  logic                        i_clk_25M,
    input  logic                        i_rst_n,
    input  logic                        i_test_pattern,
    input  logic [COLOR_W-1:0]          i_r,
    input  logic [COLOR_W-1:0]          i_g,
    input  logic [COLOR_W-1:0]          i_b,
    output logic [$clog2(H_ACTIVE)-1:0] o_x,
    output logic [$clog2(V_ACTIVE)-1:0] o_y,
    output logic                        o_req,
    output logic                        o_line_start,
    output logic                        o_frame_start,
    output logic [7:0]                  VGA_R,
    output logic [7:0]                  VGA_G,
    output logic [7:0]                  VGA_B,
    output logic                        VGA_HS,
    output logic                        VGA_VS,
    output logic                        VGA_BLANK_N,
    output logic                        VGA_SYNC_N,
    output logic                        VGA_CLK
);

    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOT);
    localparam int VW       = $clog2(V_TOT);
    localparam int XW       = $clog2(H_ACTIVE);
    localparam int YW       = $clog2(V_ACTIVE);
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int BAR_W    = H_ACTIVE / 8;

    // Everything the output stage needs about one counter position, delayed as a unit.
    typedef struct packed {
        logic       vis;
        logic       hs_act;
        logic       vs_act;
        logic       mode;
        logic [2:0] bar_rgb;
    } pipe_t;

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_mode;
    logic          w_vis;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_mode_now;
    logic [2:0]    w_bar;
    pipe_t         w_now;
    pipe_t         w_del;
    logic [7:0]    w_r;
    logic [7:0]    w_g;
    logic [7:0]    w_b;

    always_ff @(posedge i_clk_25M) begin
        if (!i_rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == HW'(H_TOT - 1)) begin
            r_h <= '0;
            r_v <= (r_v == VW'(V_TOT - 1)) ? '0 : r_v + VW'(1);
        end else begin
            r_h <= r_h + HW'(1);
        end
    end

    assign w_vis         = (r_h < HW'(H_ACTIVE)) && (r_v < VW'(V_ACTIVE));
    assign w_hs_act      = (r_h >= HW'(HS_FIRST)) && (r_h <= HW'(HS_LAST));
    assign w_vs_act      = (r_v >= VW'(VS_FIRST)) && (r_v <= VW'(VS_LAST));
    assign o_req         = w_vis;
    assign o_x           = w_vis ? r_h[XW-1:0] : '0;
    assign o_y           = w_vis ? r_v[YW-1:0] : '0;
    assign o_line_start  = (r_h == '0);
    assign o_frame_start = (r_h == '0) && (r_v == '0);

    always_ff @(posedge i_clk_25M) begin
        if (!i_rst_n) begin
            r_mode <= 1'b0;
        end else if (o_frame_start) begin
            r_mode <= i_test_pattern;
        end
    end

    // The first pixel of a frame must already see the newly sampled mode.
    assign w_mode_now = o_frame_start ? i_test_pattern : r_mode;

    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r_h >= HW'(k * BAR_W)) begin
                w_bar = 3'(k);
            end
        end
    end

    // Bar order white..black maps to {R,G,B} = {~bar[1], ~bar[2], ~bar[0]}.
    always_comb begin
        w_now         = '0;
        w_now.vis     = w_vis;
        w_now.hs_act  = w_hs_act;
        w_now.vs_act  = w_vs_act;
        w_now.mode    = w_mode_now;
        w_now.bar_rgb = {~w_bar[1], ~w_bar[2], ~w_bar[0]};
    end

    generate
        if (PIPE_LAT == 0) begin : g_no_pipe
            assign w_del = w_now;
        end else begin : g_pipe
            pipe_t r_pipe [PIPE_LAT];

            // NOTE: the delay line is reset explicitly so the first PIPE_LAT outputs
            // after reset are blank with syncs inactive rather than stale data.
            always_ff @(posedge i_clk_25M) begin
                if (!i_rst_n) begin
                    for (int k = 0; k < PIPE_LAT; k++) begin
                        r_pipe[k] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_now;
                    for (int k = 1; k < PIPE_LAT; k++) begin
                        r_pipe[k] <= r_pipe[k-1];
                    end
                end
            end

            assign w_del = r_pipe[PIPE_LAT-1];
        end
    endgenerate

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_del.vis) begin
            if (w_del.mode) begin
                w_r = {8{w_del.bar_rgb[2]}};
                w_g = {8{w_del.bar_rgb[1]}};
                w_b = {8{w_del.bar_rgb[0]}};
            end else begin
                w_r = 8'(i_r) << (8 - COLOR_W);
                w_g = 8'(i_g) << (8 - COLOR_W);
                w_b = 8'(i_b) << (8 - COLOR_W);
            end
        end
    end

    always_ff @(posedge i_clk_25M) begin
        if (!i_rst_n) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_BLANK_N <= 1'b0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
        end else begin
            VGA_R       <= w_r;
            VGA_G       <= w_g;
            VGA_B       <= w_b;
            VGA_BLANK_N <= w_del.vis;
            VGA_HS      <= w_del.hs_act ? HS_POL : ~HS_POL;
            VGA_VS      <= w_del.vs_act ? VS_POL : ~VS_POL;
        end
    end

    assign VGA_SYNC_N = 1'b0;
    assign VGA_CLK    = ~i_clk_25M;

endmodule
